// File: rtl/rtc_write_sequencer_pkg.sv
// Shared constants for the RTC write sequencer: bus state encoding, register
// address map, transfer command, and phase timer width.
package rtc_write_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR_WR   = 3'd1,
        ST_ADDR_HOLD = 3'd2,
        ST_DATA_WR   = 3'd3,
        ST_DATA_HOLD = 3'd4,
        ST_DONE      = 3'd5
    } seq_state_t;

    // Wide enough for T_PHASE up to 15.
    localparam int TPW = 4;

    // Element 0 (seconds) sits in the least significant byte.
    localparam logic [10:0][7:0] ADDR_TABLE = {
        8'h44, 8'h43, 8'h42, 8'h41, 8'h27, 8'h26,
        8'h25, 8'h24, 8'h23, 8'h22, 8'h21
    };

    localparam logic [7:0] CMD_ADDR = 8'hF1;
    localparam logic [7:0] CMD_DATA = 8'h00;

endpackage

// File: rtl/rtc_bus_phase_timer.sv
// Loadable down-counter timing one bus phase; phase_end_o is high while the count is 0.
// Load takes priority over counting; the count holds at 0 until reloaded.
module rtc_bus_phase_timer
    import rtc_write_sequencer_pkg::*;
(
    input  logic           clk,
    input  logic           reset_n,
    input  logic           load_i,
    input  logic [TPW-1:0] load_val_i,
    output logic           phase_end_o
);

    logic [TPW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign phase_end_o = (cnt_q == '0);

endmodule

// File: rtl/rtc_write_sequencer.sv
// Writes the latched register bytes (plus optional transfer command) to the RTC over
// the multiplexed A/D bus. All bus outputs are registered, one cycle behind the FSM state.
module rtc_write_sequencer
    import rtc_write_sequencer_pkg::*;
#(
    parameter int T_PHASE    = 4,
    parameter int NUM_REGS   = 11,
    parameter int CMD_ENABLE = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [8*NUM_REGS-1:0] datos_in,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            indice,
    output logic [7:0]            ad_out,
    output logic                  ad_oe,
    output logic                  ad_sel,
    output logic                  cs_n,
    output logic                  wr_n,
    output logic                  rd_n
);

    localparam logic [TPW-1:0] PHASE_LOAD = TPW'(T_PHASE - 1);
    localparam logic [3:0]     NREG       = 4'(NUM_REGS);
    localparam logic [3:0]     LAST_IDX   = (CMD_ENABLE != 0) ? 4'(NUM_REGS) : 4'(NUM_REGS - 1);

    seq_state_t                  state_q, state_d;
    logic [3:0]                  idx_q, idx_d;
    logic [NUM_REGS-1:0][7:0]    shadow_q, shadow_d;
    logic                        tmr_load, phase_end, accept;
    logic [7:0]                  cur_addr, cur_data;

    logic       busy_q, busy_d, done_q, done_d, ad_oe_q, ad_oe_d;
    logic       ad_sel_q, ad_sel_d, cs_n_q, cs_n_d, wr_n_q, wr_n_d;
    logic [3:0] indice_q, indice_d;
    logic [7:0] ad_out_q, ad_out_d;

    rtc_bus_phase_timer u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_i      (tmr_load),
        .load_val_i  (PHASE_LOAD),
        .phase_end_o (phase_end)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        tmr_load = 1'b0;
        accept   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                // busy_q still covers the registered DONE cycle, so start is held off until it drops
                if (start && !busy_q) begin
                    accept   = 1'b1;
                    shadow_d = datos_in;
                    tmr_load = 1'b1;
                    state_d  = ST_ADDR_WR;
                end
            end
            ST_ADDR_WR: if (phase_end) begin
                tmr_load = 1'b1;
                state_d  = ST_ADDR_HOLD;
            end
            ST_ADDR_HOLD: if (phase_end) begin
                tmr_load = 1'b1;
                state_d  = ST_DATA_WR;
            end
            ST_DATA_WR: if (phase_end) begin
                tmr_load = 1'b1;
                state_d  = ST_DATA_HOLD;
            end
            ST_DATA_HOLD: if (phase_end) begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    tmr_load = 1'b1;
                    idx_d    = idx_q + 1'b1;
                    state_d  = ST_ADDR_WR;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign cur_addr = (idx_q < NREG) ? ADDR_TABLE[idx_q] : CMD_ADDR;
    assign cur_data = (idx_q < NREG) ? shadow_q[idx_q]   : CMD_DATA;

    always_comb begin
        busy_d   = accept || (state_q != ST_IDLE);
        done_d   = 1'b0;
        indice_d = idx_q;
        ad_out_d = ad_out_q;
        ad_oe_d  = 1'b0;
        ad_sel_d = 1'b0;
        cs_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        case (state_q)
            ST_IDLE:      ad_out_d = '0;
            ST_ADDR_WR:   begin ad_oe_d = 1'b1; ad_sel_d = 1'b1; cs_n_d = 1'b0; wr_n_d = 1'b0; ad_out_d = cur_addr; end
            ST_ADDR_HOLD: begin ad_oe_d = 1'b1; ad_sel_d = 1'b1; ad_out_d = cur_addr; end
            ST_DATA_WR:   begin ad_oe_d = 1'b1; cs_n_d = 1'b0; wr_n_d = 1'b0; ad_out_d = cur_data; end
            ST_DATA_HOLD: begin ad_oe_d = 1'b1; ad_out_d = cur_data; end
            ST_DONE:      done_d = 1'b1;
            default:      ad_out_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            shadow_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            indice_q <= '0;
            ad_out_q <= '0;
            ad_oe_q  <= 1'b0;
            ad_sel_q <= 1'b0;
            cs_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            indice_q <= indice_d;
            ad_out_q <= ad_out_d;
            ad_oe_q  <= ad_oe_d;
            ad_sel_q <= ad_sel_d;
            cs_n_q   <= cs_n_d;
            wr_n_q   <= wr_n_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign indice = indice_q;
    assign ad_out = ad_out_q;
    assign ad_oe  = ad_oe_q;
    assign ad_sel = ad_sel_q;
    assign cs_n   = cs_n_q;
    assign wr_n   = wr_n_q;
    assign rd_n   = 1'b1;

endmodule
